bm_reg_bridge: RTL and testbench
================================

BM_REG_BRIDGE -- requirements
Module: bm_reg_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: downstream wait limit in clk cycles, 1..65535.
REQ-002 Parameter ERR_DATA, default 32'hDEADDEAD: read data returned when a transaction times out.
REQ-003 clk  input  1  sole clock; every register is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 adr_i  input  20  upstream word address from the board-manager bus; bits 19:18 select the slave.
REQ-006 dat_i  input  32  upstream write data.
REQ-007 dat_o  output  32  upstream read data; valid while ack_o is high.
REQ-008 en_i  input  1  upstream request; held high until ack_o, then dropped.
REQ-009 wr_i  input  1  1 means write, 0 means read; qualified by en_i.
REQ-010 wstrb_i  input  4  byte write strobes.
REQ-011 ack_o  output  1  one-cycle completion pulse to upstream.
REQ-012 m_adr_o  output  18  slave word address, equal to adr_i[17:0].
REQ-013 m_dat_o  output  32  slave write data.
REQ-014 m_en_o  output  4  one-hot slave enable.
REQ-015 m_wr_o  output  1  slave write flag.
REQ-016 m_wstrb_o  output  4  slave byte strobes.
REQ-017 m_dat_i  input  128  slave read data; slave n drives bits [32n+31:32n].
REQ-018 m_ack_i  input  4  per-slave acknowledge pulses.
REQ-019 errcnt_o  output  8  saturating count of timed-out transactions.

Function
REQ-020 The state machine SHALL have four states: IDLE, ACCESS, RESP and RELEASE.
REQ-021 IDLE: when en_i=1, register adr_i, dat_i, wr_i and wstrb_i, set m_en_o[adr_i[19:18]]=1 on the next cycle, and go to ACCESS. Request-to-m_en_o latency is 1 cycle.
REQ-022 ACCESS: hold the m_* outputs stable and increment the wait counter every cycle.
REQ-023 ACCESS: when m_ack_i of the selected slave is 1, capture its m_dat_i slice into dat_o, clear m_en_o and go to RESP.
REQ-024 m_ack_i bits of non-selected slaves SHALL be ignored in every state.
REQ-025 ACCESS timeout: when the counter reaches TIMEOUT-1 with no valid ack, load ERR_DATA into dat_o, clear m_en_o, increment errcnt_o (saturating at 255) and go to RESP.
REQ-026 If a valid ack and timeout expiry occur in the same cycle, the ack SHALL win: slave data is returned and errcnt_o is unchanged.
REQ-027 RESP: ack_o=1 for exactly one cycle, then go to RELEASE. Slave ack to ack_o latency is 1 cycle.
REQ-028 On writes, dat_o SHALL still be loaded (slave data or ERR_DATA); upstream ignores it.
REQ-029 RELEASE: wait until en_i=0, then go to IDLE. This prevents a held en_i from launching a duplicate transaction.
REQ-030 m_wr_o, m_dat_o, m_wstrb_o and m_adr_o SHALL come from the registered request only, never combinationally from the upstream inputs.
REQ-031 dat_o SHALL hold its last value outside RESP.
REQ-032 At most one slave SHALL be enabled at a time, and at most one transaction SHALL be outstanding.

Reset
REQ-033 While rst=1, the block SHALL be in IDLE with m_en_o=0, ack_o=0, m_wr_o=0, m_wstrb_o=0, m_adr_o=0, m_dat_o=0, dat_o=0, errcnt_o=0 and the wait counter at 0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no ack_o. After release, a still-high en_i SHALL start a fresh transaction.

Configuration
REQ-035 With macro BM_REG_BRIDGE_TIMEOUT_EN defined, the wait counter, ERR_DATA return and errcnt_o SHALL be implemented as in REQ-025.
REQ-036 Without BM_REG_BRIDGE_TIMEOUT_EN, ACCESS SHALL wait indefinitely for the selected m_ack_i, no counter logic SHALL exist, and errcnt_o SHALL be tied to 0.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Read: adr_i=20'h40010, en_i=1 at cycle 0 → m_en_o=4'b0010 and m_adr_o=18'h00010 at cycle 1; slave 1 acks at cycle 4 with 32'h12345678 → ack_o=1 at cycle 5 only, dat_o=32'h12345678.
- Write: adr_i=20'hC0004, wr_i=1, wstrb_i=4'b0011, dat_i=32'hA5A5A5A5 → m_en_o=4'b1000, m_wr_o=1, m_wstrb_o=4'b0011, m_dat_o=32'hA5A5A5A5 held until the slave acks; exactly one ack_o pulse.
- Timeout (macro on, TIMEOUT=8): no ack → ack_o pulses 1 cycle after the 8th ACCESS cycle with dat_o=32'hDEADDEAD and errcnt_o=1; 300 timeouts → errcnt_o=255.
- Same-cycle ack and timeout: selected ack arrives with m_dat_i slice 32'h0000BEEF on the expiry cycle → dat_o=32'h0000BEEF, errcnt_o unchanged; a non-selected ack alone → ignored.
- en_i held high 5 cycles after ack_o → no second m_en_o; drop en_i, re-raise it → a new transaction starts.
- rst pulsed during ACCESS → m_en_o=0 immediately, no ack_o; macro off with no slave ack → ack_o never asserts and errcnt_o stays 0.

Source files
------------

// File: rtl/bm_reg_if.sv
// Board-manager register bus bundle: upstream request/response plus the four-slave downstream fan-out.
// The bridge uses the slave modport; the environment that drives requests and models slaves uses master.
interface bm_reg_if;
  logic [19:0]  adr_i;
  logic [31:0]  dat_i;
  logic [31:0]  dat_o;
  logic         en_i;
  logic         wr_i;
  logic [3:0]   wstrb_i;
  logic         ack_o;
  logic [17:0]  m_adr_o;
  logic [31:0]  m_dat_o;
  logic [3:0]   m_en_o;
  logic         m_wr_o;
  logic [3:0]   m_wstrb_o;
  logic [127:0] m_dat_i;
  logic [3:0]   m_ack_i;

  modport slave (
    input  adr_i, dat_i, en_i, wr_i, wstrb_i, m_dat_i, m_ack_i,
    output dat_o, ack_o, m_adr_o, m_dat_o, m_en_o, m_wr_o, m_wstrb_o
  );

  modport master (
    output adr_i, dat_i, en_i, wr_i, wstrb_i, m_dat_i, m_ack_i,
    input  dat_o, ack_o, m_adr_o, m_dat_o, m_en_o, m_wr_o, m_wstrb_o
  );
endinterface

// File: rtl/bm_reg_bridge.sv
// Single-outstanding bridge from the board-manager bus to four register slaves.
// Define BM_REG_BRIDGE_TIMEOUT_EN to add the downstream wait timeout, ERR_DATA return and errcnt_o.
module bm_reg_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADDEAD
) (
  input  logic       clk,
  input  logic       rst,
  bm_reg_if.slave    bus,
  output logic [7:0] errcnt_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [17:0] m_adr_q, m_adr_d;
  logic [31:0] m_dat_q, m_dat_d;
  logic [3:0]  m_en_q, m_en_d;
  logic        m_wr_q, m_wr_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        ack_q, ack_d;
  logic        sel_ack;
  logic [31:0] sel_dat;

  // Only the enabled slave's ack counts; m_en_q is zero outside ACCESS.
  assign sel_ack = |(bus.m_ack_i & m_en_q);
  assign sel_dat = bus.m_dat_i[{sel_q, 5'b00000} +: 32];

`ifdef BM_REG_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  errcnt_q, errcnt_d;
  assign errcnt_o = errcnt_q;
`else
  assign errcnt_o = 8'h00;
`endif

  always_comb begin
    state_d   = state_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    m_en_d    = m_en_q;
    m_wr_d    = m_wr_q;
    m_wstrb_d = m_wstrb_q;
    sel_d     = sel_q;
    dat_o_d   = dat_o_q;
    ack_d     = 1'b0;
`ifdef BM_REG_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
    errcnt_d  = errcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.en_i) begin
          m_adr_d   = bus.adr_i[17:0];
          m_dat_d   = bus.dat_i;
          m_wr_d    = bus.wr_i;
          m_wstrb_d = bus.wstrb_i;
          sel_d     = bus.adr_i[19:18];
          m_en_d    = 4'b0001 << bus.adr_i[19:18];
`ifdef BM_REG_BRIDGE_TIMEOUT_EN
          cnt_d     = 16'h0000;
`endif
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
`ifdef BM_REG_BRIDGE_TIMEOUT_EN
        cnt_d = cnt_q + 16'h0001;
`endif
        // A valid ack on the expiry cycle takes priority over the timeout.
        if (sel_ack) begin
          dat_o_d = sel_dat;
          m_en_d  = 4'b0000;
          ack_d   = 1'b1;
          state_d = RESP;
        end
`ifdef BM_REG_BRIDGE_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          dat_o_d  = ERR_DATA;
          m_en_d   = 4'b0000;
          ack_d    = 1'b1;
          errcnt_d = (errcnt_q == 8'hFF) ? 8'hFF : errcnt_q + 8'h01;
          state_d  = RESP;
        end
`endif
      end
      RESP: state_d = RELEASE;
      RELEASE: begin
        if (!bus.en_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      m_en_q    <= '0;
      m_wr_q    <= 1'b0;
      m_wstrb_q <= '0;
      sel_q     <= '0;
      dat_o_q   <= '0;
      ack_q     <= 1'b0;
`ifdef BM_REG_BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
      errcnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      m_en_q    <= m_en_d;
      m_wr_q    <= m_wr_d;
      m_wstrb_q <= m_wstrb_d;
      sel_q     <= sel_d;
      dat_o_q   <= dat_o_d;
      ack_q     <= ack_d;
`ifdef BM_REG_BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      errcnt_q  <= errcnt_d;
`endif
    end
  end

  assign bus.m_adr_o   = m_adr_q;
  assign bus.m_dat_o   = m_dat_q;
  assign bus.m_en_o    = m_en_q;
  assign bus.m_wr_o    = m_wr_q;
  assign bus.m_wstrb_o = m_wstrb_q;
  assign bus.dat_o     = dat_o_q;
  assign bus.ack_o     = ack_q;
endmodule

// File: tb/tb_bm_reg_bridge.sv
// Directed bench for bm_reg_bridge: expected responses are queued at stimulus time and
// checked by an independent monitor whenever ack_o is seen; timing checks are inline.
module tb_bm_reg_bridge;
  logic       clk;
  logic       rst;
  logic [7:0] errcnt_o;

  bm_reg_if bus ();

  bm_reg_bridge #(.TIMEOUT(8), .ERR_DATA(32'hDEADDEAD)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .errcnt_o (errcnt_o)
  );

  typedef struct {
    logic [31:0] dat;
    logic [7:0]  err;
  } resp_t;

  resp_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  err_model = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every ack_o pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.ack_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(bus.ack_o), 32'h0);
        end else begin
          resp_t r;
          r = exp_q.pop_front();
          chk("sb_dat_o", bus.dat_o, r.dat);
          chk("sb_errcnt", 32'(errcnt_o), 32'(r.err));
        end
      end
    end
  end

  task automatic launch(input logic [19:0] adr, input logic wr, input logic [3:0] strb,
                        input logic [31:0] dat);
    bus.adr_i   = adr;
    bus.wr_i    = wr;
    bus.wstrb_i = strb;
    bus.dat_i   = dat;
    bus.en_i    = 1'b1;
    cyc();
  endtask

  task automatic drop();
    bus.en_i = 1'b0;
    cyc();
  endtask

  // Called on the cycle the slave acks; returns on the cycle after ack_o.
  task automatic do_ack(input int n, input logic [31:0] data, input logic [31:0] exp_dat);
    logic [127:0] bundle;
    resp_t r;
    r.dat = exp_dat;
    r.err = err_model;
    exp_q.push_back(r);
    bundle = {4{32'hBAD0BAD0}};
    bundle[32*n +: 32] = data;
    bus.m_dat_i = bundle;
    bus.m_ack_i = 4'(1 << n);
    cyc();
    bus.m_ack_i = 4'b0000;
    chk("ack_pulse_high", 32'(bus.ack_o), 32'h1);
    chk("m_en_cleared", 32'(bus.m_en_o), 32'h0);
    cyc();
    chk("ack_pulse_low", 32'(bus.ack_o), 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.adr_i   = '0;
    bus.dat_i   = '0;
    bus.en_i    = 1'b0;
    bus.wr_i    = 1'b0;
    bus.wstrb_i = '0;
    bus.m_dat_i = '0;
    bus.m_ack_i = '0;
    cyc(2);
    bus.en_i = 1'b1;
    cyc();
    chk("rst_m_en", 32'(bus.m_en_o), 32'h0);
    chk("rst_ack", 32'(bus.ack_o), 32'h0);
    chk("rst_m_wr", 32'(bus.m_wr_o), 32'h0);
    chk("rst_m_wstrb", 32'(bus.m_wstrb_o), 32'h0);
    chk("rst_m_adr", 32'(bus.m_adr_o), 32'h0);
    chk("rst_m_dat", bus.m_dat_o, 32'h0);
    chk("rst_dat_o", bus.dat_o, 32'h0);
    chk("rst_errcnt", 32'(errcnt_o), 32'h0);
    bus.en_i = 1'b0;
    rst = 1'b0;
    cyc();

    // Read from slave 1, ack on cycle 4.
    launch(20'h40010, 1'b0, 4'b0000, 32'h0);
    chk("rd_m_en", 32'(bus.m_en_o), 32'h2);
    chk("rd_m_adr", 32'(bus.m_adr_o), 32'h00010);
    cyc();
    chk("rd_no_early_ack", 32'(bus.ack_o), 32'h0);
    cyc(2);
    do_ack(1, 32'h12345678, 32'h12345678);
    chk("rd_dat_o_held", bus.dat_o, 32'h12345678);
    drop();

    // Write to slave 3; upstream inputs change after launch and must not leak through.
    launch(20'hC0004, 1'b1, 4'b0011, 32'hA5A5A5A5);
    bus.dat_i   = 32'h0;
    bus.wr_i    = 1'b0;
    bus.wstrb_i = 4'b0000;
    bus.adr_i   = 20'h00000;
    for (int i = 0; i < 5; i++) begin
      chk("wr_m_en", 32'(bus.m_en_o), 32'h8);
      chk("wr_m_wr", 32'(bus.m_wr_o), 32'h1);
      chk("wr_m_wstrb", 32'(bus.m_wstrb_o), 32'h3);
      chk("wr_m_dat", bus.m_dat_o, 32'hA5A5A5A5);
      chk("wr_m_adr", 32'(bus.m_adr_o), 32'h00004);
      cyc();
    end
    do_ack(3, 32'h11112222, 32'h11112222);
    drop();

    // en_i held after ack_o must not relaunch; re-raising it must.
    launch(20'h80008, 1'b0, 4'b0000, 32'h0);
    chk("hold_m_en", 32'(bus.m_en_o), 32'h4);
    cyc();
    do_ack(2, 32'h0A0B0C0D, 32'h0A0B0C0D);
    for (int i = 0; i < 5; i++) begin
      chk("hold_no_relaunch", 32'(bus.m_en_o), 32'h0);
      cyc();
    end
    drop();
    launch(20'h80008, 1'b0, 4'b0000, 32'h0);
    chk("relaunch_m_en", 32'(bus.m_en_o), 32'h4);
    do_ack(2, 32'h55667788, 32'h55667788);
    drop();

    // Acks from non-selected slaves are ignored.
    launch(20'h80100, 1'b0, 4'b0000, 32'h0);
    bus.m_dat_i = {4{32'h77777777}};
    bus.m_ack_i = 4'b1011;
    cyc();
    bus.m_ack_i = 4'b0000;
    chk("stray_no_ack", 32'(bus.ack_o), 32'h0);
    chk("stray_m_en", 32'(bus.m_en_o), 32'h4);
    cyc();
    chk("stray_no_ack2", 32'(bus.ack_o), 32'h0);
    do_ack(2, 32'hCAFE0002, 32'hCAFE0002);
    drop();

`ifdef BM_REG_BRIDGE_TIMEOUT_EN
    // Timeout: eight ACCESS cycles with no ack, then ERR_DATA.
    launch(20'hC0000, 1'b0, 4'b0000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("to_no_ack_yet", 32'(bus.ack_o), 32'h0);
      if (i == 7) begin
        resp_t r;
        err_model = err_model + 8'h01;
        r.dat = 32'hDEADDEAD;
        r.err = err_model;
        exp_q.push_back(r);
      end
      cyc();
    end
    chk("to_ack", 32'(bus.ack_o), 32'h1);
    chk("to_dat_o", bus.dat_o, 32'hDEADDEAD);
    chk("to_errcnt", 32'(errcnt_o), 32'h1);
    cyc();
    drop();

    // Selected ack exactly on the expiry cycle wins.
    launch(20'h00020, 1'b0, 4'b0000, 32'h0);
    cyc(7);
    do_ack(0, 32'h0000BEEF, 32'h0000BEEF);
    chk("race_errcnt", 32'(errcnt_o), 32'h1);
    drop();

    // Saturation of the error counter.
    for (int k = 0; k < 300; k++) begin
      resp_t r;
      launch({k[1:0], 18'h00100}, 1'b0, 4'b0000, 32'h0);
      err_model = (err_model == 8'hFF) ? 8'hFF : err_model + 8'h01;
      r.dat = 32'hDEADDEAD;
      r.err = err_model;
      exp_q.push_back(r);
      cyc(9);
      drop();
    end
    chk("errcnt_saturated", 32'(errcnt_o), 32'hFF);
`else
    // Without the timeout a missing ack stalls forever; recover with reset.
    launch(20'h80004, 1'b0, 4'b0000, 32'h0);
    for (int i = 0; i < 20; i++) begin
      chk("noto_no_ack", 32'(bus.ack_o), 32'h0);
      chk("noto_m_en", 32'(bus.m_en_o), 32'h4);
      cyc();
    end
    chk("noto_errcnt", 32'(errcnt_o), 32'h0);
    rst = 1'b1;
    bus.en_i = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
`endif

    // Reset mid-ACCESS aborts without ack; a held en_i then starts afresh.
    launch(20'h40044, 1'b0, 4'b0000, 32'h0);
    cyc(2);
    rst = 1'b1;
    #1;
    chk("abort_m_en", 32'(bus.m_en_o), 32'h0);
    chk("abort_ack", 32'(bus.ack_o), 32'h0);
    chk("abort_errcnt", 32'(errcnt_o), 32'h0);
    err_model = 8'h00;
    cyc();
    rst = 1'b0;
    cyc();
    chk("fresh_m_en", 32'(bus.m_en_o), 32'h2);
    chk("fresh_m_adr", 32'(bus.m_adr_o), 32'h00044);
    cyc();
    do_ack(1, 32'h0BADF00D, 32'h0BADF00D);
    drop();

    cyc(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
